// File: rtl/tile_painter.sv
// Pipelined VGA tile painter: logo strip, icon tile grid with blinking cursor,
// status band and background, colour delay-matched to vid_on (3 clk).
module tile_painter #(
    parameter int          H_ACTIVE     = 640,
    parameter int          V_ACTIVE     = 480,
    parameter int          TOP_ROWS     = 100,
    parameter int          GRID_COLS    = 20,
    parameter int          GRID_ROWS    = 10,
    parameter int          TS_LOG2      = 5,
    parameter int          TILE_AW      = 8,
    parameter int          LOGO_AW      = 16,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] TRANSPARENT  = 12'hF0F,
    parameter logic [11:0] GRID_BG      = 12'h008,
    parameter logic [11:0] BOTTOM_COLOR = 12'h0FF,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter logic [11:0] BLANK_COLOR  = 12'h000,
    parameter logic [11:0] CURSOR_COLOR = 12'hFF0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [9:0]             pixel_x,
    input  logic [9:0]             pixel_y,
    input  logic                   vid_on,
    input  logic                   cursor_en,
    input  logic [4:0]             cursor_col,
    input  logic [4:0]             cursor_row,
    output logic [TILE_AW-1:0]     tile_addr,
    input  logic [3:0]             tile_code,
    output logic [2:0]             icon_sel,
    output logic [2*TS_LOG2-1:0]   icon_addr,
    input  logic [11:0]            icon_pixel,
    output logic [LOGO_AW-1:0]     logo_addr,
    input  logic [11:0]            logo_pixel,
    output logic [11:0]            screen_color
);

    localparam int CW = 10 - TS_LOG2;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [9:0] TOP_Y      = 10'(TOP_ROWS);
    localparam logic [9:0] GRID_Y_END = 10'(TOP_ROWS + (GRID_ROWS << TS_LOG2));
    localparam logic [9:0] GRID_X_END = 10'(GRID_COLS << TS_LOG2);
    localparam logic [9:0] V_END      = 10'(V_ACTIVE);

    localparam logic [1:0] R_TOP    = 2'd0;
    localparam logic [1:0] R_GRID   = 2'd1;
    localparam logic [1:0] R_BOTTOM = 2'd2;
    localparam logic [1:0] R_OUT    = 2'd3;

    localparam logic [2:0] ICON_EMPTY = 3'd0;
    localparam logic [2:0] ICON_SHIP  = 3'd1;
    localparam logic [2:0] ICON_HIT   = 3'd2;
    localparam logic [2:0] ICON_MISS  = 3'd3;

    // Assert asynchronously, release on the second clock edge.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= '0;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    logic [1:0]         region_c;
    logic [9:0]         gy_c;
    logic [TILE_AW-1:0] tile_addr_c;

    always_comb begin
        gy_c        = pixel_y - TOP_Y;
        tile_addr_c = TILE_AW'(gy_c[9:TS_LOG2]) * TILE_AW'(GRID_COLS)
                    + TILE_AW'(pixel_x[9:TS_LOG2]);
        region_c    = R_OUT;
        if (pixel_y < TOP_Y)
            region_c = R_TOP;
        else if (pixel_y < GRID_Y_END && pixel_x < GRID_X_END)
            region_c = R_GRID;
        else if (pixel_y >= GRID_Y_END && pixel_y < V_END)
            region_c = R_BOTTOM;
    end

    logic [1:0]         s0_region;
    logic [TS_LOG2-1:0] s0_tx, s0_ty;
    logic [CW-1:0]      s0_col, s0_row;
    logic               s0_vid;
    logic [9:0]         s0_x, s0_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_region <= '0;
            s0_tx     <= '0;
            s0_ty     <= '0;
            s0_col    <= '0;
            s0_row    <= '0;
            s0_vid    <= 1'b0;
            s0_x      <= '0;
            s0_y      <= '0;
            tile_addr <= '0;
        end else begin
            s0_region <= region_c;
            s0_tx     <= pixel_x[TS_LOG2-1:0];
            s0_ty     <= gy_c[TS_LOG2-1:0];
            s0_col    <= pixel_x[9:TS_LOG2];
            s0_row    <= gy_c[9:TS_LOG2];
            s0_vid    <= vid_on;
            s0_x      <= pixel_x;
            s0_y      <= pixel_y;
            if (region_c == R_GRID) tile_addr <= tile_addr_c;
        end
    end

    // Frame start is the rising edge of the origin so held coordinates count once.
    logic          origin, origin_d, frame_start;
    logic [BW-1:0] blink_cnt;
    logic          blink_off;

    assign origin      = (pixel_x == '0) && (pixel_y == '0);
    assign frame_start = origin && !origin_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            origin_d  <= 1'b0;
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else begin
            origin_d <= origin;
            if (frame_start) begin
                if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    blink_off <= ~blink_off;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    logic [2:0] sel_c;
    logic       hit_c;

    always_comb begin
        case (tile_code)
            4'd1:    sel_c = ICON_SHIP;
            4'd2:    sel_c = ICON_HIT;
            4'd3:    sel_c = ICON_MISS;
            default: sel_c = ICON_EMPTY;
        endcase
        hit_c = cursor_en && !blink_off && (s0_region == R_GRID)
             && (10'(s0_col) == 10'(cursor_col)) && (10'(s0_row) == 10'(cursor_row))
             && (s0_tx == '0 || s0_tx == '1 || s0_ty == '0 || s0_ty == '1);
    end

    logic [1:0] s1_region;
    logic       s1_vid, s1_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icon_sel  <= ICON_EMPTY;
            icon_addr <= '0;
            logo_addr <= '0;
            s1_region <= '0;
            s1_vid    <= 1'b0;
            s1_hit    <= 1'b0;
        end else begin
            icon_sel  <= sel_c;
            icon_addr <= {s0_ty, s0_tx};
            logo_addr <= LOGO_AW'(32'(s0_y) * 32'(H_ACTIVE) + 32'(s0_x));
            s1_region <= s0_region;
            s1_vid    <= s0_vid;
            s1_hit    <= hit_c;
        end
    end

    logic [11:0] color_c;

    always_comb begin
        if (!s1_vid)                    color_c = BLANK_COLOR;
        else if (s1_hit)                color_c = CURSOR_COLOR;
        else if (s1_region == R_TOP)    color_c = logo_pixel;
        else if (s1_region == R_GRID)   color_c = (icon_pixel == TRANSPARENT) ? GRID_BG : icon_pixel;
        else if (s1_region == R_BOTTOM) color_c = BOTTOM_COLOR;
        else                            color_c = BG_COLOR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) screen_color <= BLANK_COLOR;
        else        screen_color <= color_c;
    end

endmodule

// File: tb/tb_tile_painter.sv
// Scoreboard bench for tile_painter: stimulus pushes model colours, a monitor
// pops one per output cycle; external tile RAM / icon ROM / logo ROM are modelled here.
module tb_tile_painter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  pixel_x = '0, pixel_y = '0;
    logic        vid_on = 1'b0;
    logic        cursor_en = 1'b0;
    logic [4:0]  cursor_col = '0, cursor_row = '0;
    logic [7:0]  tile_addr;
    logic [3:0]  tile_code;
    logic [2:0]  icon_sel;
    logic [9:0]  icon_addr;
    logic [11:0] icon_pixel;
    logic [15:0] logo_addr;
    logic [11:0] logo_pixel;
    logic [11:0] screen_color;

    always #5 clk = ~clk;

    tile_painter dut (
        .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y), .vid_on(vid_on),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .tile_addr(tile_addr), .tile_code(tile_code), .icon_sel(icon_sel),
        .icon_addr(icon_addr), .icon_pixel(icon_pixel), .logo_addr(logo_addr),
        .logo_pixel(logo_pixel), .screen_color(screen_color)
    );

    function automatic logic [11:0] logo_rom(input logic [15:0] a);
        logic [15:0] v;
        v = a * 16'd37 + 16'd5;
        return v[11:0];
    endfunction

    function automatic logic [11:0] icon_rom(input logic [2:0] s, input logic [9:0] a);
        if (a[1:0] == 2'b11) return 12'hF0F;
        return {s, a[9:2], 1'b0} ^ 12'h5A5;
    endfunction

    logic [3:0] tram [256];
    assign tile_code  = tram[tile_addr];
    assign icon_pixel = icon_rom(icon_sel, icon_addr);
    assign logo_pixel = logo_rom(logo_addr);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Reference model state
    int frames = 0;
    bit prev_origin = 0;

    function automatic logic [11:0] model(input int x, input int y, input bit v);
        int gy, col, row, tx, ty, code;
        bit grid, hit;
        if (!v) return 12'h000;
        gy = y - 100;
        if (y < 100) return logo_rom(16'((y * 640 + x) % 65536));
        grid = (y < 420) && (x < 640);
        if (grid) begin
            col = x / 32; row = gy / 32; tx = x % 32; ty = gy % 32;
            hit = cursor_en && ((frames / 30) % 2 == 0) && col == int'(cursor_col)
               && row == int'(cursor_row) && (tx == 0 || tx == 31 || ty == 0 || ty == 31);
            if (hit) return 12'hFF0;
            code = int'(tram[row * 20 + col]);
            if (code > 3) code = 0;
            if (icon_rom(3'(code), 10'(ty * 32 + tx)) == 12'hF0F) return 12'h008;
            return icon_rom(3'(code), 10'(ty * 32 + tx));
        end
        if (y >= 420 && y < 480) return 12'h0FF;
        return 12'h000;
    endfunction

    typedef struct { logic [11:0] col; int x; int y; } exp_t;
    exp_t exp_q[$];
    bit   pushed = 0;
    logic [2:0] vpipe;

    always @(posedge clk or negedge rst) begin
        if (!rst) vpipe <= '0;
        else      vpipe <= {vpipe[1:0], pushed};
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (vpipe[2]) begin
                if (exp_q.size() == 0) begin
                    chk("queue_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("color(%0d,%0d)", e.x, e.y), 32'(screen_color), 32'(e.col));
                end
            end
        end
    end

    task automatic drive(input int x, input int y, input bit v);
        bit o;
        exp_t e;
        @(negedge clk);
        pixel_x = 10'(x); pixel_y = 10'(y); vid_on = v;
        o = (x == 0 && y == 0);
        if (o && !prev_origin) frames++;
        prev_origin = o;
        e.col = model(x, y, v); e.x = x; e.y = y;
        exp_q.push_back(e);
        pushed = 1;
    endtask

    // Cursor inputs are sampled one edge after the pixel; fence the change with a blank pixel.
    task automatic set_cursor(input bit en, input int c, input int r);
        drive(1, 0, 0);
        #6;
        cursor_en = en; cursor_col = 5'(c); cursor_row = 5'(r);
    endtask

    task automatic do_reset_release();
        @(negedge clk);
        #3 rst = 1'b1;
        repeat (4) drive(1, 0, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin : stim
        int x, y, n;
        for (int i = 0; i < 256; i++) tram[i] = 4'($urandom);
        tram[22] = 4'd2;

        #12;
        chk("rst_color", 32'(screen_color), 32'h000);
        chk("rst_tile_addr", 32'(tile_addr), 32'd0);
        chk("rst_icon_sel", 32'(icon_sel), 32'd0);
        chk("rst_icon_addr", 32'(icon_addr), 32'd0);
        chk("rst_logo_addr", 32'(logo_addr), 32'd0);
        do_reset_release();

        repeat (3) drive(0, 0, 1);
        chk("logo_addr_origin", 32'(logo_addr), 32'd0);
        repeat (3) drive(5, 1, 1);
        chk("logo_addr_5_1", 32'(logo_addr), 32'd645);
        repeat (3) drive(70, 140, 1);
        chk("tile_addr_70_140", 32'(tile_addr), 32'd22);
        chk("icon_sel_70_140", 32'(icon_sel), 32'd2);
        chk("icon_addr_70_140", 32'(icon_addr), {22'd0, 5'd8, 5'd6});
        drive(71, 140, 1);
        drive(639, 200, 1);
        drive(100, 430, 1);
        drive(100, 430, 0);
        drive(300, 50, 0);
        drive(639, 99, 1);
        drive(0, 100, 1);
        drive(639, 419, 1);
        drive(0, 420, 1);
        drive(639, 479, 1);

        set_cursor(1, 2, 1);
        drive(64, 132, 1);
        drive(80, 148, 1);
        drive(95, 163, 1);
        drive(70, 140, 1);
        set_cursor(1, 25, 1);
        drive(64, 132, 1);
        drive(639, 132, 1);
        set_cursor(1, 3, 12);
        drive(96, 100, 1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0)
                set_cursor(1'($urandom_range(0, 3) != 0), $urandom_range(0, 24), $urandom_range(0, 12));
            if ($urandom_range(0, 2) == 0) begin
                x = (int'(cursor_col) % 20) * 32 + $urandom_range(0, 31);
                y = 100 + (int'(cursor_row) % 10) * 32 + $urandom_range(0, 31);
            end else if ($urandom_range(0, 30) == 0) begin
                x = 0; y = 0;
            end else begin
                x = $urandom_range(0, 639); y = $urandom_range(0, 479);
            end
            n = $urandom_range(1, 2);
            repeat (n) drive(x, y, 1'($urandom_range(0, 7) != 0));
        end

        drive(5, 1, 1);
        drive(6, 1, 1);
        drive(7, 1, 1);
        drive(70, 140, 1);
        #2 rst = 1'b0;
        exp_q.delete();
        pushed = 0; frames = 0; prev_origin = 0;
        #1;
        chk("midrst_color", 32'(screen_color), 32'h000);
        chk("midrst_tile_addr", 32'(tile_addr), 32'd0);
        repeat (2) @(negedge clk);
        do_reset_release();
        drive(5, 1, 1);
        drive(70, 140, 1);
        drive(100, 430, 1);

        set_cursor(1, 2, 1);
        for (int f = 1; f <= 60; f++) begin
            repeat (4) drive(0, 0, 1);
            drive(64, 132, 1);
            drive(80, 148, 1);
        end

        @(negedge clk);
        pushed = 0;
        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
